// File: rtl/gate_check_pkg.sv
// Shared state encoding and reference truth tables for the gate truth checker.
// Truth-table bit v is the required gate output for input vector v.
package gate_check_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_NAND2 = 4'b0111;
  localparam logic [3:0] TT_NOR2  = 4'b0001;
  localparam logic [3:0] TT_XOR2  = 4'b0110;
  localparam logic [1:0] TT_NOT1  = 2'b01;

endpackage

// File: rtl/vector_sequencer.sv
// Walks the input vector space and times the settle window ahead of each sample.
// The settle counter runs 1..SETTLE_CYCLES; the vector only moves on a sample cycle.
module vector_sequencer #(
  parameter int N_INPUTS      = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                in_settle,
  input  logic                in_sample,
  output logic [N_INPUTS-1:0] vec,
  output logic                settle_done,
  output logic                sample_strobe,
  output logic                last_vec
);

  localparam int CW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

  logic [CW-1:0] settle_cnt;

  assign settle_done   = in_settle && (settle_cnt == CW'(SETTLE_CYCLES));
  assign sample_strobe = in_sample;
  assign last_vec      = (vec == {N_INPUTS{1'b1}});

  always_ff @(posedge clk) begin
    if (reset) begin
      vec        <= '0;
      settle_cnt <= CW'(1);
    end else if (load) begin
      vec        <= '0;
      settle_cnt <= CW'(1);
    end else if (in_sample) begin
      // Next vector is presented on SETTLE entry; the last one holds into DONE.
      settle_cnt <= CW'(1);
      if (!last_vec) vec <= vec + N_INPUTS'(1);
    end else if (in_settle && !settle_done) begin
      settle_cnt <= settle_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/gate_truth_checker.sv
// Self-running exhaustive checker for an N-input combinational gate: drives every
// vector, samples after a settle window and records error count and first failure.
module gate_truth_checker
  import gate_check_pkg::*;
#(
  parameter int                        N_INPUTS      = 2,
  parameter int                        SETTLE_CYCLES = 1,
  parameter logic [2**N_INPUTS-1:0]    EXPECTED      = 4'b1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic [N_INPUTS-1:0] dut_in,
  input  logic                dut_out,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_INPUTS:0]   err_count,
  output logic                fail_valid,
  output logic [N_INPUTS-1:0] fail_vec
);

  state_t              state_q, state_d;
  logic                load;
  logic [N_INPUTS-1:0] vec;
  logic                settle_done, sample_strobe, last_vec;
  logic                mismatch;
  logic [N_INPUTS:0]   err_nxt;

  vector_sequencer #(
    .N_INPUTS      (N_INPUTS),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_seq (
    .clk           (clk),
    .reset         (reset),
    .load          (load),
    .in_settle     (state_q == SETTLE),
    .in_sample     (state_q == SAMPLE),
    .vec           (vec),
    .settle_done   (settle_done),
    .sample_strobe (sample_strobe),
    .last_vec      (last_vec)
  );

  assign dut_in   = vec;
  assign busy     = (state_q == SETTLE) || (state_q == SAMPLE);
  assign done     = (state_q == DONE);
  assign mismatch = sample_strobe && (dut_out != EXPECTED[vec]);
  assign err_nxt  = err_count + (N_INPUTS+1)'(mismatch);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = SETTLE;
        load    = 1'b1;
      end
      SETTLE: if (settle_done) state_d = SAMPLE;
      SAMPLE: state_d = last_vec ? DONE : SETTLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        pass       <= 1'b0;
        err_count  <= '0;
        fail_valid <= 1'b0;
        fail_vec   <= '0;
      end else if (sample_strobe) begin
        err_count <= err_nxt;
        // Only the first mismatch of a run is latched.
        if (mismatch && !fail_valid) begin
          fail_valid <= 1'b1;
          fail_vec   <= vec;
        end
        if (last_vec) pass <= (err_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Scoreboard bench: three checker instances (AND S=1, AND S=3, NOT S=1) driven by
// directed and random gate behaviours; a negedge monitor checks every busy cycle and run end.
module tb_gate_truth_checker;
  import gate_check_pkg::*;

  typedef struct {
    int inst;
    int err;
    int fv;
    int fvec;
    int pass;
    int lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_r   [3];
  logic       start_r [3];
  logic [3:0] tt_act  [3];
  logic       dout    [3];
  logic [1:0] din_w   [3];
  logic       busy_w  [3], done_w [3], pass_w [3], fv_w [3];
  logic [2:0] err_w   [3];
  logic [1:0] fvec_w  [3];

  logic       d2_in, d2_fvec;
  logic [1:0] d2_err;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  assign dout[0] = tt_act[0][din_w[0]];
  assign dout[1] = tt_act[1][din_w[1]];
  assign dout[2] = tt_act[2][din_w[2]];
  assign din_w[2]  = {1'b0, d2_in};
  assign err_w[2]  = {1'b0, d2_err};
  assign fvec_w[2] = {1'b0, d2_fvec};

  gate_truth_checker #(.N_INPUTS(2), .SETTLE_CYCLES(1), .EXPECTED(TT_AND2)) u0 (
    .clk(clk), .reset(rst_r[0]), .start(start_r[0]), .dut_in(din_w[0]), .dut_out(dout[0]),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_count(err_w[0]),
    .fail_valid(fv_w[0]), .fail_vec(fvec_w[0]));

  gate_truth_checker #(.N_INPUTS(2), .SETTLE_CYCLES(3), .EXPECTED(TT_AND2)) u1 (
    .clk(clk), .reset(rst_r[1]), .start(start_r[1]), .dut_in(din_w[1]), .dut_out(dout[1]),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_count(err_w[1]),
    .fail_valid(fv_w[1]), .fail_vec(fvec_w[1]));

  gate_truth_checker #(.N_INPUTS(1), .SETTLE_CYCLES(1), .EXPECTED(TT_NOT1)) u2 (
    .clk(clk), .reset(rst_r[2]), .start(start_r[2]), .dut_in(d2_in), .dut_out(dout[2]),
    .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .err_count(d2_err),
    .fail_valid(fv_w[2]), .fail_vec(d2_fvec));

  function automatic int ni(input int i);
    return (i == 2) ? 1 : 2;
  endfunction

  function automatic int sf(input int i);
    return (i == 1) ? 3 : 1;
  endfunction

  // Reference gate: inverter for instance 2, two-input AND otherwise.
  function automatic int ref_out(input int i, input int v);
    if (i == 2) return (v == 0) ? 1 : 0;
    return ((v & 2) != 0 && (v & 1) != 0) ? 1 : 0;
  endfunction

  function automatic exp_t model(input int i, input logic [3:0] tt);
    exp_t e;
    int   nv;
    e = '{inst: i, err: 0, fv: 0, fvec: 0, pass: 0, lat: 0};
    nv = 1 << ni(i);
    for (int v = 0; v < nv; v++) begin
      if (int'(tt[v]) != ref_out(i, v)) begin
        if (e.fv == 0) begin
          e.fv   = 1;
          e.fvec = v;
        end
        e.err++;
      end
    end
    e.pass = (e.err == 0) ? 1 : 0;
    e.lat  = nv * (sf(i) + 1);
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int want);
    n_vec++;
    if (act != want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, want, $time);
    end
  endtask

  task automatic run(input int i, input logic [3:0] tt, input bit glitch);
    int c;
    tt_act[i] = tt;
    exp_q.push_back(model(i, tt));
    @(negedge clk) start_r[i] = 1'b1;
    @(negedge clk) start_r[i] = 1'b0;
    if (glitch) begin
      // start accepted at edges 3 and 5 after the run began must be ignored
      @(negedge clk) start_r[i] = 1'b1;
      @(negedge clk) start_r[i] = 1'b0;
      @(negedge clk) start_r[i] = 1'b1;
      @(negedge clk) start_r[i] = 1'b0;
    end
    c = 0;
    while (!done_w[i] && c < 200) begin
      @(negedge clk);
      c++;
    end
    if (!done_w[i]) begin
      chk($sformatf("timeout_inst%0d", i), 0, 1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    @(negedge clk);
  endtask

  // Monitor: per-cycle vector/hold check while busy, full result check when done rises.
  initial begin
    int   k      [3];
    bit   busy_p [3];
    bit   done_p [3];
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      k[i] = 0; busy_p[i] = 0; done_p[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (busy_w[i] === 1'b1) begin
          if (!busy_p[i]) begin
            k[i] = 1;
            chk($sformatf("i%0d_clr_done", i), int'(done_w[i]), 0);
            chk($sformatf("i%0d_clr_err", i), int'(err_w[i]), 0);
            chk($sformatf("i%0d_clr_fv", i), int'(fv_w[i]), 0);
            chk($sformatf("i%0d_clr_pass", i), int'(pass_w[i]), 0);
          end else begin
            k[i]++;
          end
          chk($sformatf("i%0d_dut_in_k%0d", i, k[i]), int'(din_w[i]), (k[i] - 1) / (sf(i) + 1));
        end else if (done_w[i] === 1'b1 && !done_p[i]) begin
          if (exp_q.size() == 0) begin
            chk($sformatf("i%0d_unexpected_done", i), 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("i%0d_inst", i), i, e.inst);
            chk($sformatf("i%0d_latency", i), k[i], e.lat);
            chk($sformatf("i%0d_err_count", i), int'(err_w[i]), e.err);
            chk($sformatf("i%0d_fail_valid", i), int'(fv_w[i]), e.fv);
            chk($sformatf("i%0d_fail_vec", i), int'(fvec_w[i]), e.fvec);
            chk($sformatf("i%0d_pass", i), int'(pass_w[i]), e.pass);
          end
        end
        busy_p[i] = (busy_w[i] === 1'b1);
        done_p[i] = (done_w[i] === 1'b1);
      end
    end
  end

  task automatic chk_idle(input int i, input string tag);
    chk({tag, "_busy"}, int'(busy_w[i]), 0);
    chk({tag, "_done"}, int'(done_w[i]), 0);
    chk({tag, "_pass"}, int'(pass_w[i]), 0);
    chk({tag, "_err"}, int'(err_w[i]), 0);
    chk({tag, "_fv"}, int'(fv_w[i]), 0);
    chk({tag, "_fvec"}, int'(fvec_w[i]), 0);
    chk({tag, "_din"}, int'(din_w[i]), 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_r[i] = 1'b1; start_r[i] = 1'b0; tt_act[i] = 4'b0000;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) rst_r[i] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk_idle(i, $sformatf("reset_i%0d", i));

    // Instance 0: AND, settle 1
    run(0, 4'b1000, 0);            // correct gate
    run(0, 4'b0000, 0);            // stuck-at-0
    run(0, 4'b0111, 0);            // NAND against AND table
    run(0, 4'b1000, 1);            // start pulses mid-run ignored
    run(0, 4'b1000, 0);            // restart from DONE

    // Reset in the SAMPLE cycle of vector 2 with a NAND gate
    tt_act[0] = 4'b0111;
    @(negedge clk) start_r[0] = 1'b1;
    @(negedge clk) start_r[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrun_err_before_reset", int'(err_w[0]), 2);
    chk("midrun_din_before_reset", int'(din_w[0]), 2);
    rst_r[0] = 1'b1;
    @(negedge clk) rst_r[0] = 1'b0;
    chk_idle(0, "midrun_reset");
    run(0, 4'b1000, 0);

    for (int r = 0; r < 8; r++) run(0, 4'($urandom_range(0, 15)), 0);

    // Instance 1: AND, settle 3
    run(1, 4'b1000, 0);
    for (int r = 0; r < 3; r++) run(1, 4'($urandom_range(0, 15)), 0);

    // Instance 2: inverter against NOT table
    run(2, 4'b0001, 0);
    for (int r = 0; r < 3; r++) run(2, 4'($urandom_range(0, 3)), 0);

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) chk("scoreboard_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
